// File: rtl/clkdiv_fractional.sv
`timescale 1ns/1ps
// Fractional clock divider: mixes output periods of idiv and idiv+1 clkin cycles,
// steered by a phase accumulator, to average int_div + frac_div/2^FRAC_W.
module clkdiv_fractional #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 2
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              en,
  input  logic [INT_W-1:0]  int_div,
  input  logic [FRAC_W-1:0] frac_div,
  output logic              clkout
);

  localparam int CW = INT_W + 1;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic [CW-1:0]     p;
  logic [CW-1:0]     p_next;
  logic [CW-1:0]     idiv;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_next;
  logic [FRAC_W:0]   sum;
  logic [CW:0]       high_len;
  logic              start;
  logic              clk_next;

  always_comb begin
    idiv     = ({1'b0, int_div} < CW'(2)) ? CW'(2) : {1'b0, int_div};
    sum      = {1'b0, acc} + {1'b0, frac_div};
    // p is only zero while cleared, so it doubles as the "first active cycle" marker
    start    = (p == '0) || (cnt == p - CW'(1));
    cnt_next = cnt + CW'(1);
    p_next   = p;
    acc_next = acc;
    if (start) begin
      cnt_next = '0;
      acc_next = sum[FRAC_W-1:0];
      p_next   = sum[FRAC_W] ? idiv + CW'(1) : idiv;
    end
    high_len = ({1'b0, p_next} + (CW+1)'(1)) >> 1;
    clk_next = {1'b0, cnt_next} < high_len;
  end

  always_ff @(posedge clkin) begin
    if (rst || !en) begin
      cnt    <= '0;
      p      <= '0;
      acc    <= '0;
      clkout <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      p      <= p_next;
      acc    <= acc_next;
      clkout <= clk_next;
    end
  end

endmodule

// File: tb/tb_clkdiv_fractional.sv
`timescale 1ns/1ps
// Self-checking bench for clkdiv_fractional: cycle-level reference model plus
// hand-computed period and high-time expectations for each configuration.
module tb_clkdiv_fractional;

  localparam int Q = 4;

  logic       clkin = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] int_div;
  logic [1:0] frac_div;
  logic       clkout;

  int checks = 0;
  int passes = 0;

  clkdiv_fractional #(.INT_W(8), .FRAC_W(2)) dut (
    .clkin(clkin), .rst(rst), .en(en),
    .int_div(int_div), .frac_div(frac_div), .clkout(clkout)
  );

  always #0.5 clkin = ~clkin;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    else
      passes++;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] i, input logic [1:0] f);
    @(posedge clkin);
    #0.2;
    rst = r; en = e; int_div = i; frac_div = f;
  endtask

  // Reference: period k length follows from the running total of fractional parts
  int  m_run = 0, m_pos = 0, m_len = 0, m_phase = 0, m_idiv;
  logic exp_clk = 1'b0;

  always @(posedge clkin) begin
    if (rst || !en) begin
      m_run = 0; m_pos = 0; m_len = 0; m_phase = 0; exp_clk = 1'b0;
    end else begin
      if (!m_run || m_pos == m_len - 1) begin
        m_idiv  = (int_div < 2) ? 2 : int'(int_div);
        m_len   = m_idiv + (m_phase + int'(frac_div)) / Q - m_phase / Q;
        m_phase = m_phase + int'(frac_div);
        m_pos   = 0;
        m_run   = 1;
      end else begin
        m_pos++;
      end
      exp_clk = (m_pos < (m_len + 1) / 2);
    end
  end

  // Edge log: rise-to-rise spacings and high-phase lengths, in clkin cycles
  int cyc = 0, last_rise = -1, high_run = 0;
  logic prev = 1'b0;
  int spacing[$];
  int highs[$];

  always @(negedge clkin) begin
    checkOutput("clkout_vs_model", clkout, exp_clk);
    cyc++;
    if (clkout === 1'b1) begin
      if (!prev) begin
        if (last_rise >= 0) spacing.push_back(cyc - last_rise);
        last_rise = cyc;
      end
      high_run++;
    end else if (prev) begin
      highs.push_back(high_run);
      high_run = 0;
    end
    prev = (clkout === 1'b1);
  end

  task automatic clearLog();
    spacing.delete(); highs.delete();
    last_rise = -1; high_run = 0;
  endtask

  task automatic checkSpacing(input string name, input int idx, input int want);
    checkOutput(name, (idx < spacing.size()) ? spacing[idx] : -1, want);
  endtask

  task automatic checkHigh(input string name, input int idx, input int want);
    checkOutput(name, (idx < highs.size()) ? highs[idx] : -1, want);
  endtask

  task automatic runConfig(input logic [7:0] i, input logic [1:0] f, input int cycles);
    applyStimulus(1'b0, 1'b0, i, f);
    repeat (2) @(posedge clkin);
    clearLog();
    applyStimulus(1'b0, 1'b1, i, f);
    repeat (cycles) @(posedge clkin);
    @(negedge clkin);
  endtask

  int seq3[4] = '{3, 3, 3, 4};
  int seq56[4] = '{5, 6, 5, 6};
  int seq36[4] = '{3, 6, 6, 7};
  int win;
  logic found;
  logic lastv;

  initial begin
    rst = 1'b1; en = 1'b1; int_div = 8'd3; frac_div = 2'd1;
    repeat (10) @(posedge clkin);
    @(negedge clkin);
    checkOutput("reset_low", clkout, 1'b0);

    clearLog();
    applyStimulus(1'b0, 1'b1, 8'd3, 2'd1);
    @(posedge clkin); @(negedge clkin);
    checkOutput("startup_high", clkout, 1'b1);
    repeat (3260) @(posedge clkin);
    @(negedge clkin);
    checkOutput("period_count_ok", spacing.size() >= 1000, 1);
    for (int k = 0; k < 8; k++) checkSpacing("spacing_3_1", k, seq3[k % 4]);
    win = 0;
    for (int k = 100; k < 200; k++) win += (k < spacing.size()) ? spacing[k] : 0;
    checkOutput("avg_window_325ns", win, 325);

    // drop en one cycle into a high phase
    found = 1'b0; lastv = 1'b1;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clkin);
      if (clkout === 1'b1 && !lastv) found = 1'b1;
      lastv = (clkout === 1'b1);
    end
    checkOutput("found_high_phase", found, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd3, 2'd1);
    @(posedge clkin); @(negedge clkin);
    checkOutput("disable_low", clkout, 1'b0);
    repeat (4) begin
      @(negedge clkin);
      checkOutput("disabled_stays_low", clkout, 1'b0);
    end
    clearLog();
    applyStimulus(1'b0, 1'b1, 8'd3, 2'd1);
    @(posedge clkin); @(negedge clkin);
    checkOutput("reenable_high", clkout, 1'b1);
    repeat (20) @(posedge clkin);
    for (int k = 0; k < 4; k++) checkSpacing("reenable_seq", k, seq3[k]);

    $display("[TB] integer divide by 4");
    runConfig(8'd4, 2'd0, 30);
    for (int k = 0; k < 6; k++) begin
      checkSpacing("div4_period", k, 4);
      checkHigh("div4_high", k, 2);
    end

    $display("[TB] divide by 5.5");
    runConfig(8'd5, 2'd2, 50);
    for (int k = 0; k < 4; k++) begin
      checkSpacing("div5_5_period", k, seq56[k]);
      checkHigh("div5_5_high", k, 3);
    end

    $display("[TB] int_div 1 and 0 clamp to 2");
    runConfig(8'd1, 2'd0, 16);
    for (int k = 0; k < 5; k++) begin
      checkSpacing("div1_period", k, 2);
      checkHigh("div1_high", k, 1);
    end
    runConfig(8'd0, 2'd0, 16);
    for (int k = 0; k < 5; k++) begin
      checkSpacing("div0_period", k, 2);
      checkHigh("div0_high", k, 1);
    end

    $display("[TB] int_div 3 -> 6 mid-period");
    applyStimulus(1'b0, 1'b0, 8'd3, 2'd1);
    repeat (2) @(posedge clkin);
    clearLog();
    applyStimulus(1'b0, 1'b1, 8'd3, 2'd1);
    @(posedge clkin);
    applyStimulus(1'b0, 1'b1, 8'd6, 2'd1);
    repeat (40) @(posedge clkin);
    for (int k = 0; k < 4; k++) checkSpacing("reconfig_seq", k, seq36[k]);

    $display("[TB] reset mid-period");
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clkin);
      if (clkout === 1'b1) found = 1'b1;
    end
    checkOutput("found_high_before_reset", found, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd6, 2'd1);
    @(posedge clkin); @(negedge clkin);
    checkOutput("reset_mid_low", clkout, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd6, 2'd1);
    @(posedge clkin); @(negedge clkin);
    checkOutput("after_reset_high", clkout, 1'b1);
    repeat (10) @(posedge clkin);
    @(negedge clkin);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
